// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported 16-bit memory between the
// instruction-fetch (IF) and load/store (LS) requesters of the processor.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [15:0] ls_addr,
    input  logic [15:0] ls_wdata,
    output logic        ls_ack,
    output logic [15:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       win_ls;
    logic       last_ls;
    logic       we_r;
    logic       grant;
    logic       grant_ls;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_ls   = 1'b0;
        case (state)
            IDLE: begin
                if (!halt && (if_req || ls_req)) begin
                    grant      = 1'b1;
                    grant_ls   = ls_req && (!if_req || !last_ls);
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT:  if (cnt == 4'd0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mem_en = (state == ISSUE);
    assign mem_we = mem_en && we_r;
    assign busy   = (state != IDLE);
    assign if_ack = (state == DONE) && !win_ls;
    assign ls_ack = (state == DONE) && win_ls;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            win_ls    <= 1'b0;
            last_ls   <= 1'b1;
            we_r      <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            if_rdata  <= 16'h0000;
            ls_rdata  <= 16'h0000;
        end else begin
            if (grant) begin
                win_ls    <= grant_ls;
                last_ls   <= grant_ls;
                we_r      <= grant_ls && ls_we;
                mem_addr  <= grant_ls ? ls_addr : if_addr;
                mem_wdata <= grant_ls ? ls_wdata : 16'h0000;
            end
            if (state == ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT) begin
                // Stores complete without touching ls_rdata.
                if (cnt == 4'd0) begin
                    if (!win_ls)    if_rdata <= mem_rdata;
                    else if (!we_r) ls_rdata <= mem_rdata;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for ties, round-robin, halt and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, halt;
    logic        if_req, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr, ls_wdata;
    logic        if_ack, ls_ack, mem_en, mem_we, busy;
    logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        reset4, if_req4;
    logic [15:0] if_addr4;
    logic        if_ack4, ls_ack4, mem_en4, mem_we4, busy4;
    logic [15:0] if_rdata4, ls_rdata4, mem_addr4, mem_wdata4, mem_rdata4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset4), .halt(1'b0),
        .if_req(if_req4), .if_addr(if_addr4), .if_ack(if_ack4), .if_rdata(if_rdata4),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0000), .ls_wdata(16'h0000),
        .ls_ack(ls_ack4), .ls_rdata(ls_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4)
    );

    // Memory model: fixed preload contents, overridden by stores from u_dut1.
    // Read data is valid only in the cycle MEM_LAT after mem_en, DEAD otherwise.
    bit          written [0:65535];
    logic [15:0] wmem    [0:65535];
    logic [15:0] rd1;
    logic [15:0] p4 [4];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hB0A5;
            16'h0020: return 16'h1357;
            16'hFFFF: return 16'h7E57;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return written[a] ? wmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        rd1   <= mem_en ? mem_rd(mem_addr) : 16'hDEAD;
        p4[0] <= mem_en4 ? mem_rd(mem_addr4) : 16'hDEAD;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    assign mem_rdata  = rd1;
    assign mem_rdata4 = p4[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; halt = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ls;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_if;
        logic [15:0] exp_ls;
    } vec_t;

    vec_t tbl [7];

    task automatic run_txn(input vec_t v);
        int          lat, n_en;
        logic        got, saw_we;
        logic [15:0] s_addr, s_wdata;
        lat = 0; n_en = 0; got = 1'b0; saw_we = 1'b0; s_addr = 16'h0; s_wdata = 16'h0;
        if (v.ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (mem_en) begin
                n_en++; saw_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
            end
            if (v.ls ? ls_ack : if_ack) begin
                got = 1'b1;
                lat = i;
                chk("wrong_port_ack", v.ls ? if_ack : ls_ack, 0);
                chk("if_rdata", if_rdata, v.exp_if);
                chk("ls_rdata", ls_rdata, v.exp_ls);
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("ack_latency", lat, 3);
        chk("strobe_count", n_en, 1);
        chk("strobe_we", saw_we, v.ls && v.we);
        chk("strobe_addr", s_addr, v.addr);
        if (v.ls && v.we) chk("strobe_wdata", s_wdata, v.wdata);
        tick();
        chk("idle_after_txn", busy, 0);
    endtask

    initial begin
        int if_ack_c, ls_ack_c, ls_en_c, n_en, n_busy, n_ack, k;
        int order [8];

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB0A5, 16'h1357};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'hB0A5, 16'h1357};
        tbl[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB0A5, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h7E57, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h7E57, 16'hBEEF};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h7E57, 16'h0001};
        tbl[6] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 16'h0001};

        reset = 1'b1; reset4 = 1'b1; halt = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = 16'h0; ls_addr = 16'h0; ls_wdata = 16'h0;
        if_req4 = 1'b0; if_addr4 = 16'h0;
        tick(); tick(); tick();
        reset = 1'b0; reset4 = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_acks", {if_ack, ls_ack}, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_ls_rdata", ls_rdata, 16'h0000);
        chk("rst4_busy", busy4, 0);

        // Single fetch, exact cycle-by-cycle timing
        if_addr = 16'h0010; if_req = 1'b1;
        tick();
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_addr", mem_addr, 16'h0010);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_if_ack", if_ack, 0);
        tick();
        chk("t2_mem_en", mem_en, 0);
        chk("t2_if_ack", if_ack, 0);
        chk("t2_busy", busy, 1);
        tick();
        chk("t3_if_ack", if_ack, 1);
        chk("t3_if_rdata", if_rdata, 16'hB0A5);
        chk("t3_ls_ack", ls_ack, 0);
        if_req = 1'b0;
        tick();
        chk("t4_if_ack", if_ack, 0);
        chk("t4_busy", busy, 0);

        // Simultaneous requests after reset: IF first, then LS
        do_reset();
        if_ack_c = -1; ls_ack_c = -1; ls_en_c = -1; n_en = 0;
        if_addr = 16'h0010; if_req = 1'b1;
        ls_addr = 16'h0020; ls_we = 1'b0; ls_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (mem_en) begin
                n_en++;
                if (mem_addr == 16'h0020) ls_en_c = i;
            end
            chk("ack_overlap", if_ack && ls_ack, 0);
            if (if_ack) begin if_ack_c = i; if_req = 1'b0; end
            if (ls_ack) begin ls_ack_c = i; ls_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("tie_if_ack_cycle", if_ack_c, 3);
        chk("tie_ls_en_cycle", ls_en_c, 5);
        chk("tie_ls_ack_cycle", ls_ack_c, 7);
        chk("tie_strobes", n_en, 2);
        chk("tie_ls_rdata", ls_rdata, 16'h1357);
        chk("tie_if_rdata", if_rdata, 16'hB0A5);

        // Table of single transactions
        for (int v = 0; v < 7; v++) run_txn(tbl[v]);

        // Round-robin with both requesters continuously requesting
        do_reset();
        for (int j = 0; j < 8; j++) order[j] = -1;
        k = 0;
        if_addr = 16'h0010; if_req = 1'b1;
        ls_addr = 16'h0020; ls_we = 1'b0; ls_req = 1'b1;
        for (int i = 0; i < 60 && k < 8; i++) begin
            tick();
            chk("rr_ack_overlap", if_ack && ls_ack, 0);
            if (if_ack && k < 8) begin order[k] = 0; k++; end
            if (ls_ack && k < 8) begin order[k] = 1; k++; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        for (int j = 0; j < 8; j++) chk($sformatf("rr_grant_%0d", j), order[j], j % 2);
        tick(); tick();

        // halt blocks grants; halt rising mid-access does not stop it
        do_reset();
        halt = 1'b1; if_addr = 16'h0020; if_req = 1'b1;
        n_en = 0; n_busy = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_en += int'(mem_en);
            n_busy += int'(busy);
        end
        chk("halt_no_strobe", n_en, 0);
        chk("halt_not_busy", n_busy, 0);
        halt = 1'b0;
        tick();
        chk("halt_t11_mem_en", mem_en, 1);
        halt = 1'b1;
        tick();
        chk("halt_t12_if_ack", if_ack, 0);
        tick();
        chk("halt_t13_if_ack", if_ack, 1);
        chk("halt_t13_if_rdata", if_rdata, 16'h1357);
        if_req = 1'b0;
        tick();
        chk("halt_t14_busy", busy, 0);
        halt = 1'b0;

        // MEM_LAT=4: reset in the second WAIT cycle abandons the fetch
        if_addr4 = 16'h0020; if_req4 = 1'b1;
        tick();
        chk("r4_t1_mem_en", mem_en4, 1);
        tick();
        tick();
        chk("r4_t3_busy", busy4, 1);
        reset4 = 1'b1;
        tick();
        chk("r4_post_busy", busy4, 0);
        chk("r4_post_mem_en", mem_en4, 0);
        chk("r4_post_if_rdata", if_rdata4, 16'h0000);
        reset4 = 1'b0; if_req4 = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_ack += int'(if_ack4);
        end
        chk("r4_no_ack", n_ack, 0);
        if_addr4 = 16'h0010; if_req4 = 1'b1;
        if_ack_c = -1;
        for (int i = 1; i <= 15 && if_ack_c < 0; i++) begin
            tick();
            if (if_ack4) begin
                if_ack_c = i;
                chk("r4_if_rdata", if_rdata4, 16'hB0A5);
                if_req4 = 1'b0;
            end
        end
        if_req4 = 1'b0;
        chk("r4_fresh_latency", if_ack_c, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
